spi_adc_slave: RTL

//  SPI responder emulating a 12-bit serial ADC; the far end of the ADC-read SPI master.

---
 rtl/spi_adc_slave.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_adc_slave.sv
// spi_adc_slave: SPI responder emulating a serial ADC, MSB-first on miso, one sample per cs_n frame.
// Define SPI_SLAVE_RXCAP_EN to add mosi capture (rx_data/rx_valid).
module spi_adc_slave #(
  parameter int DATA_W   = 12,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
`ifdef SPI_SLAVE_RXCAP_EN
  ,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
  logic                sclk_prev_q, sclk_prev_d, cs_q, cs_d;
  logic [DATA_W-1:0]   shift_q, shift_d, hold_q, hold_d, last_q, last_d;
  logic                hold_full_q, hold_full_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                done_q, done_d, abort_q, abort_d, underrun_q, underrun_d;
  logic                sclk_fall, cs_fall, cs_rise, load, start;

  // cs_n only changes state once every synchroniser stage agrees, so short glitches are dropped
  assign sclk_fall = sclk_prev_q & ~sclk_sync_q[SYNC_STG-1];
  assign cs_fall   = cs_q & ~|cs_sync_q;
  assign cs_rise   = ~cs_q & &cs_sync_q;
  assign load      = sample_valid & ~hold_full_q;
  assign start     = (state_q == IDLE) & cs_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STG-2:0], cs_n};
    sclk_prev_d = sclk_sync_q[SYNC_STG-1];
    cs_d        = cs_fall ? 1'b0 : cs_rise ? 1'b1 : cs_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = load ? sample_data : hold_q;
    hold_full_d = hold_full_q | load;
    last_d      = last_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      done_d  = bit_cnt_q == CW'(DATA_W);
      abort_d = bit_cnt_q != CW'(DATA_W);
    end else if (start) begin
      state_d     = SHIFT;
      shift_d     = hold_full_q ? hold_q : last_q;
      last_d      = shift_d;
      underrun_d  = ~hold_full_q;
      hold_full_d = load;
      bit_cnt_d   = '0;
    end else if (state_q != IDLE && sclk_fall) begin
      shift_d   = shift_q << 1;
      bit_cnt_d = (bit_cnt_q == CW'(DATA_W)) ? bit_cnt_q : bit_cnt_q + CW'(1);
      state_d   = (bit_cnt_d == CW'(DATA_W)) ? TAIL : SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_q        <= 1'b1;
      shift_q     <= '0;
      hold_q      <= '0;
      last_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_q        <= cs_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso         = (state_q == SHIFT) & shift_q[DATA_W-1];
  assign miso_oe      = state_q != IDLE;
  assign sample_ready = ~hold_full_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign underrun     = underrun_q;

`ifdef SPI_SLAVE_RXCAP_EN
  logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, sclk_rise;

  // mosi shares the sclk pipeline depth, so it is aligned with the detected rise
  assign sclk_rise = ~sclk_prev_q & sclk_sync_q[SYNC_STG-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], mosi};
    rx_shift_d  = start ? '0
                : (state_q == SHIFT && sclk_rise && !cs_rise) ? {rx_shift_q[DATA_W-2:0], mosi_sync_q[SYNC_STG-1]}
                : rx_shift_q;
    rx_valid_d  = done_d;
    rx_data_d   = done_d ? rx_shift_q : rx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_mosi;
  assign unused_mosi = mosi;
`endif
endmodule
